// File: rtl/conv_sched_pkg.sv
// conv_sched_pkg
//   Shared definitions for the convolution tile scheduler: the default
//   widths, the scheduler state encoding, and a small engine-select helper.
package conv_sched_pkg;

  localparam int DEF_IMG_AW = 10;  // image address width
  localparam int DEF_W_AW   = 8;   // weight address width
  localparam int DEF_DW     = 24;  // result width
  localparam int DEF_CW     = 8;   // tile-count / tag width

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    LOAD,
    DRAIN,
    FINISH
  } sched_state_t;

  // One-hot engine select from an engine index bit.
  function automatic logic [1:0] eng_onehot(input logic e);
    return e ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/conv_result_slot.sv
// conv_result_slot
//   One-entry holding register for one engine's result. A capture loads the
//   data and marks the slot full; a clear empties it. The scheduler never
//   captures into a full slot, so capture and clear never coincide.
// Ports:
//   clk, rst  clock / asynchronous active-high reset
//   capture   load din and set full
//   clear     drop the held result
//   din       result word from the engine
//   full      slot holds an unread result
//   data      held result word
module conv_result_slot
  import conv_sched_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          capture,
  input  logic          clear,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic [DW-1:0] data
);

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      // NOTE: the data word is reset too, because it is visible on res_data
      // straight after reset and must read as zero.
      data <= '0;
    end else if (capture) begin
      full <= 1'b1;
      data <= din;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/conv_tile_scheduler.sv
// conv_tile_scheduler
//   Sequences cfg_tile_cnt convolution tiles onto two engines (tile k runs on
//   engine k[0]), lets only one engine use the shared RAM read port (load
//   phase) at a time, and returns results in tile order on a valid/ready
//   stream.
// Ports:
//   clk, rst                   clock / asynchronous active-high reset
//   go                         job start pulse, sampled only in IDLE
//   cfg_img_base/_stride       image address of tile 0 / step per tile
//   cfg_w_addr, cfg_tile_cnt   weight start address / number of tiles
//   busy, all_done             job running / one-cycle end-of-job pulse
//   eng_start                  per-engine start pulse
//   eng_s_img_addr, _s_w_addr  start addresses shared by both engines
//   eng_data_in_done, eng_done per-engine load-complete / result-valid
//   eng_calc_data              {engine1, engine0} results
//   res_valid/ready/data/tag   in-order result stream, tag = tile index
module conv_tile_scheduler
  import conv_sched_pkg::*;
#(
  parameter int IMG_AW = DEF_IMG_AW,
  parameter int W_AW   = DEF_W_AW,
  parameter int DW     = DEF_DW,
  parameter int CW     = DEF_CW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [IMG_AW-1:0] cfg_img_base,
  input  logic [IMG_AW-1:0] cfg_img_stride,
  input  logic [W_AW-1:0]   cfg_w_addr,
  input  logic [CW-1:0]     cfg_tile_cnt,
  output logic              busy,
  output logic              all_done,
  output logic [1:0]        eng_start,
  output logic [IMG_AW-1:0] eng_s_img_addr,
  output logic [W_AW-1:0]   eng_s_w_addr,
  input  logic [1:0]        eng_data_in_done,
  input  logic [1:0]        eng_done,
  input  logic [2*DW-1:0]   eng_calc_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DW-1:0]     res_data,
  output logic [CW-1:0]     res_tag
);

  sched_state_t      state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     issue_idx;
  logic [CW-1:0]     out_idx;
  logic [CW-1:0]     issue_next;
  logic [CW-1:0]     out_next;
  logic [IMG_AW-1:0] stride;
  logic [IMG_AW-1:0] img_addr;
  logic [W_AW-1:0]   w_addr;
  logic [1:0]        eng_busy;
  logic [1:0]        slot_full;
  logic [1:0]        free;
  logic [1:0]        capture;
  logic [1:0]        clear;
  logic [DW-1:0]     slot_data [2];
  logic              cur_e;
  logic              out_e;
  logic              in_done;
  logic              drain;

  assign cur_e      = issue_idx[0];
  assign out_e      = out_idx[0];
  assign issue_next = issue_idx + 1'b1;
  assign out_next   = out_idx + 1'b1;
  assign free       = ~eng_busy & ~slot_full;

  // Engine pulses only count while that engine is running a tile; this
  // filters stray pulses from engines that kept going through a reset.
  assign capture = eng_done & eng_busy;
  assign in_done = eng_data_in_done[cur_e] & eng_busy[cur_e];

  // Start is a decode of registered state and flags, so it is high exactly
  // for the ISSUE cycle in which the target engine is free.
  assign eng_start = (state == ISSUE && free[cur_e]) ? eng_onehot(cur_e) : 2'b00;

  assign res_valid = slot_full[out_e] &&
                     (state == ISSUE || state == LOAD || state == DRAIN);
  assign drain     = res_valid & res_ready;
  assign clear     = drain ? eng_onehot(out_e) : 2'b00;
  assign res_data  = slot_data[out_e];
  assign res_tag   = out_idx;

  assign busy           = (state != IDLE);
  assign eng_s_img_addr = img_addr;
  assign eng_s_w_addr   = w_addr;

  for (genvar g = 0; g < 2; g++) begin : g_slot
    conv_result_slot #(.DW(DW)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .capture (capture[g]),
      .clear   (clear[g]),
      .din     (eng_calc_data[g*DW +: DW]),
      .full    (slot_full[g]),
      .data    (slot_data[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      stride    <= '0;
      img_addr  <= '0;
      w_addr    <= '0;
      issue_idx <= '0;
      out_idx   <= '0;
      eng_busy  <= '0;
      all_done  <= 1'b0;
    end else begin
      all_done <= 1'b0;
      eng_busy <= (eng_busy & ~capture) | eng_start;
      if (drain) out_idx <= out_next;

      case (state)
        IDLE: begin
          if (go) begin
            cnt       <= cfg_tile_cnt;
            stride    <= cfg_img_stride;
            img_addr  <= cfg_img_base;
            w_addr    <= cfg_w_addr;
            issue_idx <= '0;
            out_idx   <= '0;
            state     <= (cfg_tile_cnt == '0) ? FINISH : ISSUE;
          end
        end
        ISSUE: begin
          if (free[cur_e]) state <= LOAD;
        end
        LOAD: begin
          // Address advances with the tile index: base + idx*stride, wrapping.
          if (in_done) begin
            issue_idx <= issue_next;
            img_addr  <= img_addr + stride;
            state     <= (issue_next == cnt) ? DRAIN : ISSUE;
          end
        end
        DRAIN: begin
          // Look through the final handshake so FINISH follows it directly.
          if (out_idx == cnt || (drain && out_next == cnt)) state <= FINISH;
        end
        FINISH: begin
          all_done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
